sdram_port_arbiter: RTL and testbench

//  Two-port arbiter sharing one SDRAM controller user interface (addr/rw/data_in/in_valid/busy/data_out/out_valid).

---
 rtl/sdram_port_arbiter_if.sv | 26 ++
 rtl/sdram_port_arbiter.sv | 115 +++++++++++
 tb/tb_sdram_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester ports and SDRAM controller user-port signals of sdram_port_arbiter
interface sdram_port_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 32
);
  logic          p0_req, p1_req, p0_rw, p1_rw;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] ctl_addr;
  logic          ctl_rw, ctl_in_valid, ctl_busy, ctl_out_valid, rd_timeout_err;
  logic [DW-1:0] ctl_wdata, ctl_rdata;
  modport master (
    input  p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  ctl_busy, ctl_rdata, ctl_out_valid,
    output p0_ack, p1_ack, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    output ctl_addr, ctl_rw, ctl_wdata, ctl_in_valid, rd_timeout_err
  );
  modport slave (
    output p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output ctl_busy, ctl_rdata, ctl_out_valid,
    input  p0_ack, p1_ack, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
    input  ctl_addr, ctl_rw, ctl_wdata, ctl_in_valid, rd_timeout_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port arbiter onto one SDRAM controller user port; define SDRAM_ARB_PRIO_EN for fixed p0 priority instead of round-robin
module sdram_port_arbiter #(
  parameter int AW = 23,
  parameter int DW = 32,
  parameter int RD_TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  sdram_port_arbiter_if.master bus
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t        state_q, state_d;
  logic          grant_q, grant_d, last_q, last_d, rw_q, rw_d, civ_q, civ_d;
  logic          rv0_q, rv0_d, rv1_q, rv1_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          win, accept;
`ifdef SDRAM_ARB_PRIO_EN
  assign win = !bus.p0_req;
`else
  assign win = (bus.p0_req && bus.p1_req) ? !last_q : bus.p1_req;
`endif
  assign accept             = (state_q == ISSUE) && !bus.ctl_busy;
  assign bus.p0_ack         = accept && !grant_q;
  assign bus.p1_ack         = accept && grant_q;
  assign bus.ctl_addr       = addr_q;
  assign bus.ctl_rw         = rw_q;
  assign bus.ctl_wdata      = wdata_q;
  assign bus.ctl_in_valid   = civ_q;
  assign bus.p0_rvalid      = rv0_q;
  assign bus.p1_rvalid      = rv1_q;
  assign bus.p0_rdata       = rd0_q;
  assign bus.p1_rdata       = rd1_q;
  assign bus.rd_timeout_err = err_q;
  // grant, hold the command until accepted, then wait for read data or timeout
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    civ_d   = civ_q;
    tmr_d   = tmr_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.p0_req || bus.p1_req) begin
        grant_d = win;
        last_d  = win;
        addr_d  = win ? bus.p1_addr : bus.p0_addr;
        rw_d    = win ? bus.p1_rw : bus.p0_rw;
        wdata_d = win ? bus.p1_wdata : bus.p0_wdata;
        civ_d   = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (!bus.ctl_busy) begin
        civ_d   = 1'b0;
        tmr_d   = '0;
        state_d = rw_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (bus.ctl_out_valid) begin
          rv0_d   = !grant_q;
          rv1_d   = grant_q;
          rd0_d   = grant_q ? rd0_q : bus.ctl_rdata;
          rd1_d   = grant_q ? bus.ctl_rdata : rd1_q;
          state_d = IDLE;
        end else if (tmr_q == TW'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; last_grant resets to p1 so p0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      civ_q   <= 1'b0;
      tmr_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      civ_q   <= civ_d;
      tmr_q   <= tmr_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scoreboard bench for sdram_port_arbiter with a simple controller model
module tb_sdram_port_arbiter;
  typedef struct packed {logic port; logic rw; logic [22:0] addr; logic [31:0] wdata;} cmd_t;
  typedef struct packed {logic port; logic [31:0] data;} rd_t;
  logic clk = 1'b0;
  logic rst;
  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  int   exp_err, checks, errors, cyc, acc_cyc, hold_cnt, rd_delay, cnt;
  logic mdl_fixed_en, pend, acc;
  logic [31:0] mdl_fixed;
  logic [22:0] la;
  sdram_port_arbiter_if #(.AW(23), .DW(32)) bus();
  sdram_port_arbiter #(.AW(23), .DW(32), .RD_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=unexpected expected=none", name);
  endtask
  function automatic void push_cmd(input logic port, input logic rw, input logic [22:0] addr, input logic [31:0] wd);
    cmd_t c;
    c.port = port; c.rw = rw; c.addr = addr; c.wdata = wd;
    exp_cmd.push_back(c);
  endfunction
  function automatic void push_rd(input logic port, input logic [31:0] d);
    rd_t r;
    r.port = port; r.data = d;
    exp_rd.push_back(r);
  endfunction
  // monitor: compares accepted commands, held commands, read returns and timeouts against the queues
  initial begin
    cmd_t c;
    rd_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.ctl_in_valid) begin
          if (exp_cmd.size() == 0) miss("cmd_unexpected");
          else begin
            c = exp_cmd[0];
            chk("cmd_addr", bus.ctl_addr, c.addr);
            chk("cmd_rw", bus.ctl_rw, c.rw);
            chk("cmd_wdata", bus.ctl_wdata, c.wdata);
            if (bus.ctl_busy) begin
              hold_cnt++;
              chk("hold_noack", {bus.p1_ack, bus.p0_ack}, 2'b00);
            end else begin
              void'(exp_cmd.pop_front());
              chk("cmd_port_ack", {bus.p1_ack, bus.p0_ack}, c.port ? 2'b10 : 2'b01);
              acc_cyc = cyc;
            end
          end
        end
        if (bus.p0_rvalid || bus.p1_rvalid) begin
          if (exp_rd.size() == 0) miss("rvalid_unexpected");
          else begin
            r = exp_rd.pop_front();
            chk("rvalid_port", {bus.p1_rvalid, bus.p0_rvalid}, r.port ? 2'b10 : 2'b01);
            chk("rdata", r.port ? bus.p1_rdata : bus.p0_rdata, r.data);
          end
        end
        if (bus.rd_timeout_err) begin
          if (exp_err == 0) miss("timeout_unexpected");
          else begin
            exp_err--;
            chk("timeout_latency", 64'(cyc - acc_cyc), 64'd65);
          end
        end
      end
    end
  end
  // controller model: out_valid rd_delay cycles after a read accept (rd_delay 0 = never)
  initial begin
    pend = 1'b0; cnt = 0; la = '0;
    forever begin
      @(negedge clk);
      acc = bus.ctl_in_valid && !bus.ctl_busy && !bus.ctl_rw && rd_delay > 0;
      if (acc) la = bus.ctl_addr;
      @(posedge clk);
      #1;
      bus.ctl_out_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          bus.ctl_out_valid = 1'b1;
          bus.ctl_rdata = mdl_fixed_en ? mdl_fixed : {16'hC0DE, la[15:0]};
        end
      end
      if (acc) begin
        pend = 1'b1;
        cnt = rd_delay;
      end
    end
  end
  task automatic do_cmd(input logic port, input logic rw, input logic [22:0] addr, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    if (port) begin bus.p1_req = 1; bus.p1_rw = rw; bus.p1_addr = addr; bus.p1_wdata = wd; end
    else begin bus.p0_req = 1; bus.p0_rw = rw; bus.p0_addr = addr; bus.p0_wdata = wd; end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = port ? bus.p1_ack : bus.p0_ack;
      @(posedge clk);
      #1;
    end
    if (port) bus.p1_req = 0; else bus.p0_req = 0;
    if (!got) miss(port ? "p1_ack_timeout" : "p0_ack_timeout");
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && (exp_cmd.size() + exp_rd.size() + exp_err) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if ((exp_cmd.size() + exp_rd.size() + exp_err) != 0) miss(name);
    repeat (3) begin @(posedge clk); #1; end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_civ"}, bus.ctl_in_valid, 0);
    chk({tag, "_addr"}, bus.ctl_addr, 0);
    chk({tag, "_rw"}, bus.ctl_rw, 0);
    chk({tag, "_wdata"}, bus.ctl_wdata, 0);
    chk({tag, "_rvalid"}, {bus.p1_rvalid, bus.p0_rvalid}, 0);
    chk({tag, "_p0_rdata"}, bus.p0_rdata, 0);
    chk({tag, "_p1_rdata"}, bus.p1_rdata, 0);
    chk({tag, "_err"}, bus.rd_timeout_err, 0);
    chk({tag, "_ack"}, {bus.p1_ack, bus.p0_ack}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    {bus.p0_req, bus.p1_req, bus.p0_rw, bus.p1_rw, bus.ctl_busy, bus.ctl_out_valid} = '0;
    {bus.p0_addr, bus.p1_addr, bus.p0_wdata, bus.p1_wdata, bus.ctl_rdata} = '0;
    exp_err = 0; checks = 0; errors = 0; cyc = 0; acc_cyc = 0; hold_cnt = 0;
    rd_delay = 0; mdl_fixed_en = 1'b0; mdl_fixed = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    // 1: p0 write, latency n+1
    push_cmd(0, 1, 23'h000104, 32'hDEADBEEF);
    bus.p0_req = 1; bus.p0_rw = 1; bus.p0_addr = 23'h000104; bus.p0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_civ_n", bus.ctl_in_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_civ_n1", bus.ctl_in_valid, 1);
    chk("t1_addr_n1", bus.ctl_addr, 23'h000104);
    chk("t1_ack_n1", bus.p0_ack, 1);
    @(posedge clk); #1;
    bus.p0_req = 0;
    @(negedge clk);
    chk("t1_civ_n2", bus.ctl_in_valid, 0);
    @(posedge clk); #1;
    // 2: p1 read, data 6 cycles after accept
    rd_delay = 6; mdl_fixed_en = 1'b1; mdl_fixed = 32'h12345678;
    push_cmd(1, 0, 23'h7FFC00, 32'h0);
    push_rd(1, 32'h12345678);
    do_cmd(1, 0, 23'h7FFC00, 32'h0);
    wait_idle("t2_drain");
    @(negedge clk);
    chk("t2_p1_rdata_hold", bus.p1_rdata, 32'h12345678);
    chk("t2_p0_rdata", bus.p0_rdata, 0);
    @(posedge clk); #1;
    // 3: four reads per port, both requesting
    rd_delay = 1; mdl_fixed_en = 1'b0;
`ifdef SDRAM_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) begin push_cmd(0, 0, 23'(16 + i), 0); push_rd(0, 32'hC0DE0010 + 32'(i)); end
    for (int i = 0; i < 4; i++) begin push_cmd(1, 0, 23'(32 + i), 0); push_rd(1, 32'hC0DE0020 + 32'(i)); end
`else
    for (int i = 0; i < 4; i++) begin
      push_cmd(0, 0, 23'(16 + i), 0); push_rd(0, 32'hC0DE0010 + 32'(i));
      push_cmd(1, 0, 23'(32 + i), 0); push_rd(1, 32'hC0DE0020 + 32'(i));
    end
`endif
    fork
      for (int i = 0; i < 4; i++) do_cmd(0, 0, 23'(16 + i), 0);
      for (int j = 0; j < 4; j++) do_cmd(1, 0, 23'(32 + j), 0);
    join
    wait_idle("t3_drain");
    // 4: controller busy for 20 cycles after the grant
    hold_cnt = 0;
    bus.ctl_busy = 1;
    push_cmd(0, 1, 23'h0ABCDE, 32'hCAFEF00D);
    fork
      do_cmd(0, 1, 23'h0ABCDE, 32'hCAFEF00D);
      begin repeat (21) @(posedge clk); #1 bus.ctl_busy = 0; end
    join
    chk("t4_hold_cycles", 64'(hold_cnt), 64'd20);
    wait_idle("t4_drain");
    // 5: read timeout, then a p1 write still goes through
    rd_delay = 0;
    exp_err = 1;
    push_cmd(0, 0, 23'h000200, 32'h0);
    push_cmd(1, 1, 23'h000300, 32'h55AA55AA);
    do_cmd(0, 0, 23'h000200, 32'h0);
    do_cmd(1, 1, 23'h000300, 32'h55AA55AA);
    wait_idle("t5_drain");
    // 6: reset during RD_WAIT discards the late read data
    rd_delay = 10;
    push_cmd(0, 0, 23'h000400, 32'h0);
    do_cmd(0, 0, 23'h000400, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    @(negedge clk);
    chk_zero("t6_post_rst");
    @(posedge clk); #1;
    push_cmd(0, 1, 23'h000500, 32'h11111111);
    push_cmd(1, 1, 23'h000600, 32'h22222222);
    fork
      do_cmd(0, 1, 23'h000500, 32'h11111111);
      do_cmd(1, 1, 23'h000600, 32'h22222222);
    join
    wait_idle("t6_drain");
    chk("sb_empty", 64'(exp_cmd.size() + exp_rd.size() + exp_err), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
